calc_cmd_sender: RTL and testbench
==================================

CALC_CMD_SENDER -- requirements
Module: calc_cmd_sender

Interface
REQ-001 Parameter: GAP, 1, number of NOP cycles inserted after every emitted command (legal range 0..7).
REQ-002 clock  input  1  rising-edge clock for all sequential logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 a  input  27  operand A in binary; legal range 0..99_999_999.
REQ-006 b  input  27  operand B in binary; legal range 0..99_999_999.
REQ-007 op  input  2  operation select: 00 plus, 01 minus, 10 multiply, 11 illegal.
REQ-008 cmd  output  4  command/digit code to the calculator: 0-9 digit, A plus, B minus, C mul, E result, F clear, D NOP.
REQ-009 cmd_valid  output  1  high in exactly the cycles where cmd carries a non-NOP command.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 err  output  1  sticky error flag; cleared when the next start is accepted.

Function
REQ-013 States SHALL be IDLE, CONV, SEND, GAP_WAIT, FIN, ERR.
REQ-014 In IDLE with start=1, a, b and op SHALL be captured into internal registers; later input changes have no effect.
REQ-015 Acceptance with a>99_999_999, b>99_999_999 or op=11 SHALL go to ERR; otherwise it SHALL go to CONV.
REQ-016 ERR SHALL last one cycle with done=1, err=1 and busy=0, emit no command, then return to IDLE.
REQ-017 CONV SHALL run a sequential double-dabble conversion of both operands in parallel into 8 BCD digits each.
REQ-018 CONV SHALL take exactly 27 cycles with busy=1, cmd=D and cmd_valid=0.
REQ-019 Significant-digit count n SHALL equal the position of the most significant nonzero BCD digit, with minimum n=1, so an operand of 0 sends a single digit 0.
REQ-020 SEND SHALL emit, one command per SEND cycle: F, then the n_A digits of A most significant first, then the op code (A/B/C), then the n_B digits of B most significant first, then E.
REQ-021 The command count SHALL be N = n_A + n_B + 3.
REQ-022 After each SEND cycle the FSM SHALL spend GAP cycles in GAP_WAIT with cmd=D and cmd_valid=0; with GAP=0, commands SHALL be back-to-back.
REQ-023 A digit/command index counter SHALL track progress; the transition after the E command plus its gap SHALL go to FIN.
REQ-024 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-025 Timing: with start sampled at edge k, CONV SHALL occupy cycles k+1..k+27.
REQ-026 Timing: the F command SHALL appear in cycle k+28.
REQ-027 Timing: done SHALL be high in cycle k+28+N*(1+GAP).
REQ-028 start while busy=1 or during FIN/ERR SHALL be ignored with no queuing.
REQ-029 start in the cycle after FIN SHALL be accepted normally.
REQ-030 Outside SEND, cmd SHALL be D.
REQ-031 Inside SEND, cmd SHALL be driven from registers, free of glitch-producing combinational paths from the inputs.
REQ-032 err SHALL be cleared in the cycle after a legal start is accepted and remain clear thereafter.
REQ-033 A start with illegal inputs SHALL re-set err.

Reset
REQ-034 On reset assertion, the FSM SHALL go to IDLE immediately, regardless of the current state.
REQ-035 On reset assertion, outputs SHALL be: cmd=D, cmd_valid=0, busy=0, done=0, err=0.
REQ-036 On reset assertion, all BCD, counter and captured-operand registers SHALL clear to 0.
REQ-037 Reset mid-sequence SHALL abandon the sequence; no further commands are emitted.
REQ-038 After reset deasserts, the first start SHALL behave as after power-up.

Verification
REQ-039 GAP=1, a=12, b=345, op=00, start at k -> valid cmds F,1,2,A,3,4,5,E at k+28,+30,...,+42; NOPs between; done at k+44.
REQ-040 GAP=1, a=0, b=0, op=10 -> valid cmds F,0,C,0,E; done at k+38; busy high k+1..k+37.
REQ-041 GAP=0, a=99_999_999, b=1, op=01 -> back-to-back cmds F,9,9,9,9,9,9,9,9,B,1,E at k+28..k+39; done at k+40.
REQ-042 Illegal a=100_000_000 -> done=1, err=1 at k+1, no valid cmd.
REQ-043 Follow-up to REQ-042: legal start -> err cleared at next cycle.
REQ-044 Reset asserted mid-SEND after the op command -> same cycle cmd=D, busy=0, cmd_valid=0.
REQ-045 Follow-up to REQ-044: start pulse while busy -> ignored, no second sequence.

Source files
------------

// File: rtl/calc_cmd_sender_if.sv
// Handshake and command bus between a requester and the calculator command sender.
interface calc_cmd_sender_if;
  logic        start;
  logic [26:0] a;
  logic [26:0] b;
  logic [1:0]  op;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, a, b, op,
    input  cmd, cmd_valid, busy, done, err
  );

  modport slave (
    input  start, a, b, op,
    output cmd, cmd_valid, busy, done, err
  );
endinterface

// File: rtl/calc_cmd_sender.sv
// Converts two binary operands to BCD and keys them into a calculator as a
// command stream: F, digits of A, op, digits of B, E, with GAP NOP cycles
// after every command.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; operands captured on acceptance
// CONV     | 27-cycle double-dabble of both operands in parallel
// SEND     | one command on cmd with cmd_valid=1
// GAP_WAIT | NOP cycles after each command
// FIN      | one-cycle done pulse after the sequence
// ERR      | one-cycle done pulse with err set, no commands emitted
module calc_cmd_sender #(
  parameter int GAP = 1
) (
  input  logic              clock,
  input  logic              reset,
  calc_cmd_sender_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CONV, SEND, GAP_WAIT, FIN, ERR} state_t;

  localparam logic [26:0] MAX_OPERAND = 27'd99_999_999;
  localparam logic [2:0]  GAP_RELOAD  = (GAP > 0) ? 3'(GAP - 1) : 3'd0;
  localparam logic [3:0]  CMD_NOP     = 4'hD;
  localparam logic [3:0]  CMD_CLR     = 4'hF;
  localparam logic [3:0]  CMD_RES     = 4'hE;
  localparam logic [3:0]  CMD_PLUS    = 4'hA;

  state_t      state, state_d;
  logic [26:0] bin_a, bin_b;
  logic [31:0] bcd_a, bcd_b;
  logic [31:0] adj_a, adj_b;
  logic [1:0]  op_q;
  logic [4:0]  conv_cnt;
  logic [4:0]  idx;
  logic [2:0]  gap_cnt;
  logic        err_q;
  logic        illegal;
  logic        last_cmd;
  logic [3:0]  n_a, n_b;
  logic [4:0]  n_a_ext, n_b_ext, n_cmds;
  logic [3:0]  cmd_sel;

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [31:0] dd_adjust(input logic [31:0] bcd);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return r;
  endfunction

  // Number of significant digits; zero still sends one digit.
  function automatic logic [3:0] sig_digits(input logic [31:0] bcd);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 1; i < 8; i++) begin
      if (bcd[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  assign illegal  = (bus.a > MAX_OPERAND) | (bus.b > MAX_OPERAND) | (bus.op == 2'b11);
  assign adj_a    = dd_adjust(bcd_a);
  assign adj_b    = dd_adjust(bcd_b);
  assign n_a      = sig_digits(bcd_a);
  assign n_b      = sig_digits(bcd_b);
  assign n_a_ext  = {1'b0, n_a};
  assign n_b_ext  = {1'b0, n_b};
  assign n_cmds   = n_a_ext + n_b_ext + 5'd3;
  assign last_cmd = (idx == n_cmds - 5'd1);
  assign bus.err  = err_q;

  // Command for the current index, selected purely from registered operand state.
  always_comb begin
    cmd_sel = CMD_RES;
    if (idx == 5'd0)
      cmd_sel = CMD_CLR;
    else if (idx <= n_a_ext)
      cmd_sel = bcd_a[{3'(n_a_ext - idx), 2'b00} +: 4];
    else if (idx == n_a_ext + 5'd1)
      cmd_sel = CMD_PLUS + {2'b00, op_q};
    else if (idx < n_cmds - 5'd1)
      cmd_sel = bcd_b[{3'(n_a_ext + n_b_ext + 5'd1 - idx), 2'b00} +: 4];
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state;
    bus.cmd       = CMD_NOP;
    bus.cmd_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_d = illegal ? ERR : CONV;
      end
      CONV: begin
        bus.busy = 1'b1;
        if (conv_cnt == 5'd0) state_d = SEND;
      end
      SEND: begin
        bus.busy      = 1'b1;
        bus.cmd       = cmd_sel;
        bus.cmd_valid = 1'b1;
        if (GAP != 0)     state_d = GAP_WAIT;
        else if (last_cmd) state_d = FIN;
      end
      GAP_WAIT: begin
        bus.busy = 1'b1;
        if (gap_cnt == 3'd0) state_d = last_cmd ? FIN : SEND;
      end
      FIN: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, conversion, command index, gap timer and sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_a    <= '0;
      bin_b    <= '0;
      bcd_a    <= '0;
      bcd_b    <= '0;
      op_q     <= '0;
      conv_cnt <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_a    <= bus.a;
            bin_b    <= bus.b;
            op_q     <= bus.op;
            bcd_a    <= '0;
            bcd_b    <= '0;
            conv_cnt <= 5'd26;
            idx      <= '0;
            gap_cnt  <= '0;
            err_q    <= illegal;
          end
        end
        CONV: begin
          bcd_a    <= (adj_a << 1) | {31'd0, bin_a[26]};
          bcd_b    <= (adj_b << 1) | {31'd0, bin_b[26]};
          bin_a    <= bin_a << 1;
          bin_b    <= bin_b << 1;
          conv_cnt <= conv_cnt - 5'd1;
        end
        SEND: begin
          if (GAP != 0)      gap_cnt <= GAP_RELOAD;
          else if (!last_cmd) idx    <= idx + 5'd1;
        end
        GAP_WAIT: begin
          if (gap_cnt == 3'd0) begin
            if (!last_cmd) idx <= idx + 5'd1;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_sender.sv
// Drives a GAP=1 and a GAP=0 instance with identical stimulus and checks every
// cycle of both against a timing/command-list model built from decimal arithmetic.
module tb_calc_cmd_sender;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [26:0] a, b;
  logic [1:0]  op;

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  always #5 clock = ~clock;

  calc_cmd_sender_if if_g1();
  calc_cmd_sender_if if_g0();

  calc_cmd_sender #(.GAP(1)) u_dut_g1 (.clock(clock), .reset(reset), .bus(if_g1));
  calc_cmd_sender #(.GAP(0)) u_dut_g0 (.clock(clock), .reset(reset), .bus(if_g0));

  assign if_g1.start = start;
  assign if_g1.a     = a;
  assign if_g1.b     = b;
  assign if_g1.op    = op;
  assign if_g0.start = start;
  assign if_g0.a     = a;
  assign if_g0.b     = b;
  assign if_g0.op    = op;

  logic [3:0] o_cmd   [2];
  logic       o_valid [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic       o_err   [2];

  assign o_cmd[0]   = if_g1.cmd;
  assign o_valid[0] = if_g1.cmd_valid;
  assign o_busy[0]  = if_g1.busy;
  assign o_done[0]  = if_g1.done;
  assign o_err[0]   = if_g1.err;
  assign o_cmd[1]   = if_g0.cmd;
  assign o_valid[1] = if_g0.cmd_valid;
  assign o_busy[1]  = if_g0.busy;
  assign o_done[1]  = if_g0.done;
  assign o_err[1]   = if_g0.err;

  // reference model state, index 0 = GAP 1, index 1 = GAP 0
  bit         m_active  [2];
  bit         m_illegal [2];
  bit         m_err     [2];
  int         m_k       [2];
  int         m_n       [2];
  int         m_last    [2];
  logic [3:0] m_cmds    [2][20];
  string      log_s     [2];
  int         done_cyc  [2];

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit m_idle(input int d, input int c);
    return !m_active[d] || (c > m_last[d]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string got, input string exp);
    checks++;
    assert (got == exp) else begin
      failures++;
      $error("FAIL %s observed=%s expected=%s", tag, got, exp);
    end
  endtask

  task automatic model_accept(input int d);
    int dg[8];
    int v, nd, n;
    m_active[d]  = 1'b1;
    m_k[d]       = e;
    m_illegal[d] = (a > 27'd99_999_999) || (b > 27'd99_999_999) || (op == 2'b11);
    m_err[d]     = m_illegal[d];
    log_s[d]     = "";
    done_cyc[d]  = -1;
    if (m_illegal[d]) begin
      m_last[d] = e + 1;
    end else begin
      n = 0;
      m_cmds[d][n] = 4'hF; n++;
      v = int'(a); nd = 0;
      do begin dg[nd] = v % 10; v = v / 10; nd++; end while (v > 0);
      for (int i = nd - 1; i >= 0; i--) begin m_cmds[d][n] = 4'(dg[i]); n++; end
      m_cmds[d][n] = 4'hA + {2'b00, op}; n++;
      v = int'(b); nd = 0;
      do begin dg[nd] = v % 10; v = v / 10; nd++; end while (v > 0);
      for (int i = nd - 1; i >= 0; i--) begin m_cmds[d][n] = 4'(dg[i]); n++; end
      m_cmds[d][n] = 4'hE; n++;
      m_n[d]    = n;
      m_last[d] = e + 28 + n * (1 + gap_of(d));
    end
  endtask

  task automatic model_edge(input int d);
    if (reset) begin
      m_active[d] = 1'b0;
      m_err[d]    = 1'b0;
    end else if (start && m_idle(d, e)) begin
      model_accept(d);
    end
  endtask

  task automatic check_cycle(input int d, input int c);
    logic [3:0] x_cmd;
    logic       x_v, x_busy, x_done;
    int         off, j, per, tot;
    x_cmd = 4'hD; x_v = 1'b0; x_busy = 1'b0; x_done = 1'b0;
    per = 1 + gap_of(d);
    if (m_active[d]) begin
      off = c - m_k[d];
      if (m_illegal[d]) begin
        x_done = (off == 1);
      end else if (off >= 1 && off <= 27) begin
        x_busy = 1'b1;
      end else if (off >= 28) begin
        j   = off - 28;
        tot = m_n[d] * per;
        if (j < tot) begin
          x_busy = 1'b1;
          if (j % per == 0) begin
            x_cmd = m_cmds[d][j / per];
            x_v   = 1'b1;
          end
        end else if (j == tot) begin
          x_done = 1'b1;
        end
      end
    end
    chk($sformatf("g%0d_cmd_c%0d", gap_of(d), c),   32'(o_cmd[d]),   32'(x_cmd));
    chk($sformatf("g%0d_valid_c%0d", gap_of(d), c), 32'(o_valid[d]), 32'(x_v));
    chk($sformatf("g%0d_busy_c%0d", gap_of(d), c),  32'(o_busy[d]),  32'(x_busy));
    chk($sformatf("g%0d_done_c%0d", gap_of(d), c),  32'(o_done[d]),  32'(x_done));
    chk($sformatf("g%0d_err_c%0d", gap_of(d), c),   32'(o_err[d]),   32'(m_err[d]));
    if (o_valid[d] === 1'b1) log_s[d] = {log_s[d], $sformatf("%h", o_cmd[d])};
    if (o_done[d] === 1'b1 && done_cyc[d] < 0) done_cyc[d] = c;
  endtask

  task automatic tick();
    @(posedge clock);
    e++;
    model_edge(0);
    model_edge(1);
    #1;
    check_cycle(0, e + 1);
    check_cycle(1, e + 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(m_idle(0, e + 1) && m_idle(1, e + 1)) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_bound"}, 32'(n < 200), 32'd1);
  endtask

  task automatic run_one(input logic [26:0] va, input logic [26:0] vb, input logic [1:0] vop,
                         input string tag);
    a = va; b = vb; op = vop; start = 1'b1;
    tick();
    start = 1'b0;
    a = 27'($urandom); b = 27'($urandom); op = 2'($urandom);
    wait_idle(tag);
  endtask

  task automatic async_reset(input int hold);
    #2 reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_err[d]    = 1'b0;
    end
    #1;
    check_cycle(0, e + 1);
    check_cycle(1, e + 1);
    repeat (hold) tick();
    #2 reset = 1'b0;
  endtask

  function automatic logic [26:0] rand_operand();
    case ($urandom_range(0, 15))
      0: return 27'd0;
      1: return 27'd99_999_999;
      2: return 27'd100_000_000;
      3: return 27'h7FF_FFFF;
      4, 5: return 27'($urandom_range(0, 9));
      6, 7: return 27'($urandom_range(0, 999));
      default: return 27'($urandom_range(0, 99_999_999));
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0; m_err[d] = 1'b0; log_s[d] = ""; done_cyc[d] = -1;
    end
    repeat (2) tick();
    #2 reset = 1'b0;
    tick();
    chk("rst_cmd_g1", 32'(o_cmd[0]), 32'hD);
    chk("rst_busy_g0", 32'(o_busy[1]), 32'd0);

    // a=12, b=345, plus
    run_one(27'd12, 27'd345, 2'b00, "t1");
    chk_s("t1_cmds_g1", log_s[0], "f12a345e");
    chk("t1_done_g1", 32'(done_cyc[0] - m_k[0]), 32'd44);
    chk_s("t1_cmds_g0", log_s[1], "f12a345e");
    chk("t1_done_g0", 32'(done_cyc[1] - m_k[1]), 32'd36);

    // zero operands, multiply
    run_one(27'd0, 27'd0, 2'b10, "t2");
    chk_s("t2_cmds_g1", log_s[0], "f0c0e");
    chk("t2_done_g1", 32'(done_cyc[0] - m_k[0]), 32'd38);
    chk("t2_done_g0", 32'(done_cyc[1] - m_k[1]), 32'd33);

    // maximum operand, minus
    run_one(27'd99_999_999, 27'd1, 2'b01, "t3");
    chk_s("t3_cmds_g0", log_s[1], "f99999999b1e");
    chk("t3_done_g0", 32'(done_cyc[1] - m_k[1]), 32'd40);
    chk("t3_done_g1", 32'(done_cyc[0] - m_k[0]), 32'd52);

    // illegal a, then legal start clears err
    a = 27'd100_000_000; b = 27'd5; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_done_g1", 32'(o_done[0]), 32'd1);
    chk("t4_err_g1", 32'(o_err[0]), 32'd1);
    chk("t4_busy_g1", 32'(o_busy[0]), 32'd0);
    chk("t4_err_g0", 32'(o_err[1]), 32'd1);
    tick();
    chk("t4_sticky_g1", 32'(o_err[0]), 32'd1);
    a = 27'd5; b = 27'd7; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_clr_g1", 32'(o_err[0]), 32'd0);
    chk("t4_clr_g0", 32'(o_err[1]), 32'd0);
    wait_idle("t4");
    chk_s("t4_cmds_g1", log_s[0], "f5a7e");

    // illegal op, then illegal b
    run_one(27'd3, 27'd4, 2'b11, "t5a");
    chk("t5a_err_g1", 32'(o_err[0]), 32'd1);
    chk_s("t5a_cmds_g1", log_s[0], "");
    run_one(27'd3, 27'h7FF_FFFF, 2'b00, "t5b");
    chk("t5b_err_g0", 32'(o_err[1]), 32'd1);

    // reset in the middle of SEND, after the op command
    a = 27'd12; b = 27'd345; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (34) tick();
    chk_s("t6_pre_g1", log_s[0], "f12a");
    chk_s("t6_pre_g0", log_s[1], "f12a345e");
    async_reset(2);
    chk("t6_cmd_g1", 32'(o_cmd[0]), 32'hD);
    chk("t6_valid_g1", 32'(o_valid[0]), 32'd0);
    chk("t6_busy_g1", 32'(o_busy[0]), 32'd0);
    chk("t6_err_g1", 32'(o_err[0]), 32'd0);

    // start pulse while busy is ignored
    a = 27'd7; b = 27'd8; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    a = 27'd9; b = 27'd9; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t7");
    chk_s("t7_cmds_g1", log_s[0], "f7c8e");
    chk("t7_done_g1", 32'(done_cyc[0] - m_k[0]), 32'd38);
    chk("t7_done_g0", 32'(done_cyc[1] - m_k[1]), 32'd33);
    repeat (40) tick();
    chk_s("t7_quiet_g1", log_s[0], "f7c8e");
    chk_s("t7_quiet_g0", log_s[1], "f7c8e");

    // start held high through FIN: re-accepted in the cycle after FIN
    a = 27'd3; b = 27'd4; op = 2'b00; start = 1'b1;
    repeat (60) tick();
    start = 1'b0;
    wait_idle("t8");

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 5) == 0);
      a     = rand_operand();
      b     = rand_operand();
      op    = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0) async_reset(1);
      else                             tick();
    end
    start = 1'b0;
    wait_idle("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
